// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and constants for the 4-channel TDM receive path.
// Optional macro TDM_PARITY_EN adds a fifth (even parity) beat per frame.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int NUM_SLOTS = 4;

`ifdef TDM_PARITY_EN
    localparam int LAST_SLOT = 4;
    localparam int SLOT_W    = 3;
`else
    localparam int LAST_SLOT = 3;
    localparam int SLOT_W    = 2;
`endif

    // Slots held in shadow before the closing beat arrives
    localparam int SHADOW_N = LAST_SLOT;

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: modulo-N slot index with beat enable and sync load-to-1.
// Modulus follows TDM_PARITY_EN through the package defaults.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int N = LAST_SLOT + 1,
    parameter int W = SLOT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         load_i,
    output logic [W-1:0] slot_o,
    output logic         wrap_o
);

    logic [W-1:0] slot_q;
    logic [W-1:0] slot_d;
    logic         last;

    assign last   = (slot_q == W'(N - 1));
    assign wrap_o = en_i && last;
    assign slot_o = slot_q;

    // Next slot: sync restarts at 1, a beat advances and wraps
    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d = W'(1);
        end else if (en_i) begin
            slot_d = last ? '0 : slot_q + W'(1);
        end
    end

    // Slot register
    always_ff @(posedge clk) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: TDM receive demux, one slot per beat into four channels.
// Optional macro TDM_PARITY_EN adds a parity beat and the parity_err port.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    input  logic              in_sync,
    output logic [WIDTH-1:0]  ch0,
    output logic [WIDTH-1:0]  ch1,
    output logic [WIDTH-1:0]  ch2,
    output logic [WIDTH-1:0]  ch3,
    output logic              out_valid,
    output logic              frame_abort,
`ifdef TDM_PARITY_EN
    output logic              parity_err,
`endif
    output logic [SLOT_W-1:0] slot
);

    state_t             state_q;
    state_t             state_d;
    logic [SLOT_W-1:0]  slot_w;
    logic               wrap;
    logic               load;
    logic               en;
    logic               abort_d;
    logic [WIDTH-1:0]   shadow_q [SHADOW_N];
    logic [WIDTH-1:0]   ch_q     [NUM_SLOTS];
    logic [WIDTH-1:0]   last_ch;
    logic               out_valid_q;
    logic               abort_q;

    tdm_slot_counter #(
        .N (LAST_SLOT + 1),
        .W (SLOT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .load_i (load),
        .slot_o (slot_w),
        .wrap_o (wrap)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= HUNT;
        else     state_q <= state_d;
    end

    // Next state: sync aligns, an unsynced slot-0 beat loses alignment
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT: if (in_valid && in_sync) state_d = RUN;
            RUN:  if (in_valid && !in_sync && slot_w == '0) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Beat decode: counter load/advance and abort detection
    always_comb begin
        load    = 1'b0;
        en      = 1'b0;
        abort_d = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                HUNT: load = in_sync;
                RUN: begin
                    if (in_sync) begin
                        load    = 1'b1;
                        abort_d = (slot_w != '0);
                    end else if (slot_w == '0) begin
                        abort_d = 1'b1;
                    end else begin
                        en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TDM_PARITY_EN
    logic [WIDTH-1:0] par_acc;
    logic             perr_q;

    assign last_ch = shadow_q[NUM_SLOTS-1];

    // Even parity over the four data slots plus the parity beat
    always_comb begin
        par_acc = in_data;
        for (int i = 0; i < SHADOW_N; i++) par_acc = par_acc ^ shadow_q[i];
    end

    // Parity error pulse, aligned with out_valid
    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= wrap && (par_acc != '0);
    end

    assign parity_err = perr_q;
`else
    assign last_ch = in_data;
`endif

    // Shadow capture, channel publish and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '{default: '0};
            ch_q        <= '{default: '0};
            out_valid_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            out_valid_q <= wrap;
            abort_q     <= abort_d;
            if (load) shadow_q[0] <= in_data;
            for (int i = 1; i < SHADOW_N; i++) begin
                if (en && slot_w == SLOT_W'(i)) shadow_q[i] <= in_data;
            end
            if (wrap) begin
                for (int i = 0; i < NUM_SLOTS - 1; i++) ch_q[i] <= shadow_q[i];
                ch_q[NUM_SLOTS-1] <= last_ch;
            end
        end
    end

    assign ch0         = ch_q[0];
    assign ch1         = ch_q[1];
    assign ch2         = ch_q[2];
    assign ch3         = ch_q[3];
    assign out_valid   = out_valid_q;
    assign frame_abort = abort_q;
    assign slot        = slot_w;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scoreboard bench for the TDM receive demux.
// Build with TDM_PARITY_EN defined to exercise the parity beat.
module tb_tdm_demux4;
    import tdm_pkg::*;

    localparam int W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [W-1:0]      in_data;
    logic              in_valid;
    logic              in_sync;
    logic [W-1:0]      ch0, ch1, ch2, ch3;
    logic              out_valid;
    logic              frame_abort;
    logic [SLOT_W-1:0] slot;
`ifdef TDM_PARITY_EN
    logic              parity_err;
`endif

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sync     (in_sync),
        .ch0         (ch0),
        .ch1         (ch1),
        .ch2         (ch2),
        .ch3         (ch3),
        .out_valid   (out_valid),
        .frame_abort (frame_abort),
`ifdef TDM_PARITY_EN
        .parity_err  (parity_err),
`endif
        .slot        (slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*W-1:0] chs;
        logic           perr;
        int             at;
    } exp_t;

    exp_t q[$];
    int   abort_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pop expected frames/aborts when the DUT reports them
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid || frame_abort)
                check("ov_abort_exclusive", 32'(out_valid & frame_abort), 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("ov_latency", cyc, e.at + 1);
                    check("channels", {ch0, ch1, ch2, ch3}, e.chs);
`ifdef TDM_PARITY_EN
                    check("parity_err", 32'(parity_err), 32'(e.perr));
`endif
                end
            end
            if (frame_abort) begin
                if (abort_q.size() == 0) begin
                    check("spurious_abort", 32'(frame_abort), 0);
                end else begin
                    int a;
                    a = abort_q.pop_front();
                    check("abort_latency", cyc, a + 1);
                end
            end
        end
    end

    task automatic beat(input logic [W-1:0] d, input logic s);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_sync  = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sync  = 1'b0;
            in_data  = W'($urandom);
        end
    endtask

    // Closing beat(s) of a frame whose first three slots were sent
    task automatic tail(input logic [W-1:0] a, b, c, d, input int gap,
                        input logic bad);
        exp_t e;
        beat(d, 1'b0);
`ifdef TDM_PARITY_EN
        idle(gap);
        beat(a ^ b ^ c ^ d ^ {W{bad}}, 1'b0);
        e.perr = bad;
`else
        e.perr = 1'b0;
`endif
        e.chs = {a, b, c, d};
        e.at  = cyc;
        q.push_back(e);
    endtask

    task automatic frame(input logic [W-1:0] a, b, c, d, input int gap);
        beat(a, 1'b1); idle(gap);
        beat(b, 1'b0); idle(gap);
        beat(c, 1'b0); idle(gap);
        tail(a, b, c, d, gap, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_ch", {ch0, ch1, ch2, ch3}, 0);
        check("rst_ov", 32'(out_valid), 0);
        check("rst_abort", 32'(frame_abort), 0);
        check("rst_slot", 32'(slot), 0);
        rst = 1'b0;

        // Unsynced beats while hunting are ignored
        beat(4'h7, 1'b0); beat(4'h6, 1'b0); idle(1);
        check("hunt_ignore_slot", 32'(slot), 0);

        // First frame A,B,C,D; channels stay 0 until it completes
        beat(4'hA, 1'b1); beat(4'hB, 1'b0); beat(4'hC, 1'b0); idle(1);
        check("pre_frame_ch", {ch0, ch1, ch2, ch3}, 0);
        check("mid_frame_slot", 32'(slot), 3);
        tail(4'hA, 4'hB, 4'hC, 4'hD, 0, 1'b0);
        idle(2);

        // Same frame with 3-cycle stalls between beats
        frame(4'hA, 4'hB, 4'hC, 4'hD, 3);
        idle(2);

        // Back-to-back frames
        frame(4'h1, 4'h2, 4'h3, 4'h4, 0);
        frame(4'h5, 4'h6, 4'h7, 4'h8, 0);
        idle(2);

        // Mid-frame resync: 1,2 then sync 9,A,B,C
        beat(4'h1, 1'b1); beat(4'h2, 1'b0);
        beat(4'h9, 1'b1);
        abort_q.push_back(cyc);
        idle(1);
        check("held_on_abort", {ch0, ch1, ch2, ch3}, 16'h5678);
        check("resync_slot", 32'(slot), 1);
        beat(4'hA, 1'b0); beat(4'hB, 1'b0);
        tail(4'h9, 4'hA, 4'hB, 4'hC, 0, 1'b0);
        idle(2);

        // Lost alignment: unsynced slot-0 beat drops to HUNT
        beat(4'h3, 1'b0);
        abort_q.push_back(cyc);
        beat(4'h4, 1'b0); beat(4'h5, 1'b0); beat(4'h6, 1'b0);
        beat(4'h7, 1'b0); beat(4'h8, 1'b0);
        idle(1);
        check("lost_slot", 32'(slot), 0);
        check("lost_held", {ch0, ch1, ch2, ch3}, 16'h9ABC);
        frame(4'hE, 4'h0, 4'hF, 4'h1, 1);
        idle(2);

`ifdef TDM_PARITY_EN
        // Good parity then deliberately wrong parity
        frame(4'h1, 4'h2, 4'h4, 4'h8, 0);
        idle(1);
        beat(4'h1, 1'b1); beat(4'h2, 1'b0); beat(4'h4, 1'b0);
        tail(4'h1, 4'h2, 4'h4, 4'h8, 0, 1'b1);
        idle(2);
`endif

        // Reset mid-frame discards partial frame and clears channels
        beat(4'h3, 1'b1); beat(4'h2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("midrst_ch", {ch0, ch1, ch2, ch3}, 0);
        check("midrst_slot", 32'(slot), 0);
        rst = 1'b0;
        frame(4'h4, 4'h3, 4'h2, 4'h1, 0);
        idle(4);

        check("frames_left", q.size(), 0);
        check("aborts_left", abort_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
